// File: rtl/walk_seq_checker.sv
// Receive-side monitor for a walking-one GPIO pattern: bit 0 up to bit NUM_PINS-1,
// one pin at a time, each held prescaler*CYCLES_PER_MS clocks (+/-TOL), then all low.
module walk_seq_checker #(
    parameter int NUM_PINS      = 34,
    parameter int CYCLES_PER_MS = 10000,
    parameter int TOL           = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                arm,
    input  logic                abort,
    input  logic [13:0]         prescaler,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic [2:0]          err_code,
    output logic [5:0]          err_pin,
    output logic [5:0]          cur_pin,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_CHECK      = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    localparam logic [2:0] ERR_BAD_CFG = 3'd1;
    localparam logic [2:0] ERR_MULTI   = 3'd2;
    localparam logic [2:0] ERR_ORDER   = 3'd3;
    localparam logic [2:0] ERR_SHORT   = 3'd4;
    localparam logic [2:0] ERR_LONG    = 3'd5;
    localparam logic [2:0] ERR_START   = 3'd6;

    localparam logic [NUM_PINS-1:0] ONE      = NUM_PINS'(1);
    localparam logic [5:0]          LAST_PIN = 6'(NUM_PINS - 1);
    localparam logic [27:0]         TOL_W    = 28'(TOL);
    localparam logic [27:0]         CNT_MAX  = '1;

    state_t        state_q, state_d;
    logic [27:0]   hold_q, hold_d;
    logic [5:0]    cur_q, cur_d;
    logic [13:0]   presc_q, presc_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic [2:0]    code_q, code_d;
    logic [5:0]    pin_q, pin_d;

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] s;
    logic                s_multi;
    logic [NUM_PINS-1:0] cur_hot, nxt_hot;
    logic [27:0]         exp_hold, lo, hi;
    logic                do_fail;
    logic [2:0]          fail_code;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign s_multi = |(s & (s - ONE));
    assign cur_hot = ONE << cur_q;
    assign nxt_hot = ONE << 6'(cur_q + 6'd1);

    // Acceptance window, clamped at both ends so it never wraps.
    assign exp_hold = 28'(presc_q) * 28'(CYCLES_PER_MS);
    assign lo       = (exp_hold >= TOL_W) ? exp_hold - TOL_W : 28'd0;
    assign hi       = (exp_hold > CNT_MAX - TOL_W) ? CNT_MAX : exp_hold + TOL_W;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cur_d     = cur_q;
        presc_d   = presc_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        code_d    = code_q;
        pin_d     = pin_q;
        do_fail   = 1'b0;
        fail_code = 3'd0;

        if (abort) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            cur_d   = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            code_d  = '0;
            pin_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (arm) begin
                        presc_d = prescaler;
                        pass_d  = 1'b0;
                        fail_d  = 1'b0;
                        code_d  = '0;
                        pin_d   = '0;
                        cur_d   = '0;
                        hold_d  = '0;
                        state_d = ST_WAIT_START;
                        if (prescaler == 14'd0) begin
                            do_fail   = 1'b1;
                            fail_code = ERR_BAD_CFG;
                        end
                    end
                end
                ST_WAIT_START: begin
                    if (s == ONE) begin
                        state_d = ST_CHECK;
                        hold_d  = 28'd1;
                    end else if (s_multi) begin
                        do_fail   = 1'b1;
                        fail_code = ERR_MULTI;
                    end else if (s != '0) begin
                        do_fail   = 1'b1;
                        fail_code = ERR_START;
                    end
                end
                ST_CHECK: begin
                    if (s == cur_hot) begin
                        if ({1'b0, hold_q} + 29'd1 > {1'b0, hi}) begin
                            do_fail   = 1'b1;
                            fail_code = ERR_LONG;
                        end else begin
                            hold_d = hold_q + 28'd1;
                        end
                    end else if (hold_q < lo) begin
                        do_fail   = 1'b1;
                        fail_code = ERR_SHORT;
                    end else if (s == nxt_hot && cur_q < LAST_PIN) begin
                        cur_d  = cur_q + 6'd1;
                        hold_d = 28'd1;
                    end else if (s == '0 && cur_q == LAST_PIN) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end else if (s_multi) begin
                        do_fail   = 1'b1;
                        fail_code = ERR_MULTI;
                    end else begin
                        do_fail   = 1'b1;
                        fail_code = ERR_ORDER;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // err_pin reports the pin that was expected when the error hit.
            if (do_fail) begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
                pass_d  = 1'b0;
                code_d  = fail_code;
                pin_d   = (state_q == ST_CHECK || state_q == ST_WAIT_START) ? cur_q : 6'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            cur_q   <= '0;
            presc_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= '0;
            pin_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cur_q   <= cur_d;
            presc_q <= presc_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            pin_q   <= pin_d;
        end
    end

    assign busy      = (state_q == ST_WAIT_START) || (state_q == ST_CHECK);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign err_code  = code_q;
    assign err_pin   = pin_q;
    assign cur_pin   = cur_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_walk_seq_checker.sv
// Directed bench for walk_seq_checker with CYCLES_PER_MS=10, TOL=2, prescaler=3
// (expected hold 30 cycles, accepted window 28..32).
module tb_walk_seq_checker;

    localparam int NP = 34;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_CHK  = 3'd2;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [13:0]   prescaler = 14'd3;
    logic [NP-1:0] gpio_in = '0;
    logic          busy, pass, fail;
    logic [2:0]    err_code;
    logic [5:0]    err_pin, cur_pin;
    logic [2:0]    state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    walk_seq_checker #(
        .NUM_PINS(NP), .CYCLES_PER_MS(10), .TOL(2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .nrst(nrst), .arm(arm), .abort(abort), .prescaler(prescaler),
        .gpio_in(gpio_in), .busy(busy), .pass(pass), .fail(fail),
        .err_code(err_code), .err_pin(err_pin), .cur_pin(cur_pin), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [NP-1:0] v, input int n);
        gpio_in = v;
        step(n);
    endtask

    task automatic pin_hold(input int idx, input int n);
        logic [NP-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        hold(v, n);
    endtask

    task automatic run_bits(input int first, input int last, input int n);
        for (int i = first; i <= last; i++) pin_hold(i, n);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    task automatic start_run();
        gpio_in = '0;
        step(4);
        pulse_arm();
    endtask

    task automatic check_fail(input string tag, input logic [2:0] code, input logic [5:0] pin);
        check({tag, "_fail"}, fail, 1);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_code"}, err_code, code);
        check({tag, "_pin"}, err_pin, pin);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [NP-1:0] v;

        step(3);
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_code", err_code, 0);
        check("rst_pin", err_pin, 0);
        check("rst_cur", cur_pin, 0);
        check("rst_state", state_dbg, ST_IDLE);
        nrst = 1'b1;
        step(2);

        // Clean run; pass appears on the third edge after the pins drop.
        pulse_arm();
        check("clean_armed_busy", busy, 1);
        check("clean_armed_state", state_dbg, ST_WAIT);
        step(3);
        check("clean_wait_state", state_dbg, ST_WAIT);
        run_bits(0, 33, 30);
        check("clean_last_cur", cur_pin, 33);
        check("clean_last_state", state_dbg, ST_CHK);
        gpio_in = '0;
        step(2);
        check("clean_pass_early", pass, 0);
        step(1);
        check("clean_pass", pass, 1);
        check("clean_fail", fail, 0);
        check("clean_code", err_code, 0);
        check("clean_busy", busy, 0);

        // Re-arm from PASS.
        pulse_arm();
        check("rearm_pass_clr", pass, 0);
        check("rearm_busy", busy, 1);
        run_bits(0, 33, 30);
        hold('0, 5);
        check("rearm_pass", pass, 1);
        check("rearm_fail", fail, 0);

        // Window edges: 28 and 32 are accepted.
        start_run();
        pin_hold(0, 28);
        pin_hold(1, 32);
        run_bits(2, 33, 30);
        hold('0, 5);
        check("bounds_pass", pass, 1);
        check("bounds_fail", fail, 0);

        start_run();
        run_bits(0, 4, 30);
        pin_hold(5, 27);
        pin_hold(6, 5);
        check_fail("short", 3'd4, 6'd5);

        // LONG must fire on the 33rd held cycle, before any transition.
        start_run();
        run_bits(0, 6, 30);
        pin_hold(7, 33);
        step(1);
        check("long_not_early", fail, 0);
        step(1);
        check_fail("long", 3'd5, 6'd7);

        start_run();
        run_bits(0, 10, 30);
        pin_hold(12, 10);
        check_fail("order", 3'd3, 6'd10);

        start_run();
        run_bits(0, 3, 30);
        v = '0;
        v[3] = 1'b1;
        v[4] = 1'b1;
        hold(v, 10);
        check_fail("multi", 3'd2, 6'd3);

        start_run();
        pin_hold(2, 10);
        check_fail("start", 3'd6, 6'd0);

        start_run();
        run_bits(0, 20, 30);
        hold('0, 10);
        check_fail("drop", 3'd3, 6'd20);

        gpio_in = '0;
        step(4);
        prescaler = 14'd0;
        pulse_arm();
        check_fail("cfg", 3'd1, 6'd0);
        prescaler = 14'd3;

        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_fail_clr", fail, 0);
        check("abort_code_clr", err_code, 0);
        check("abort_fail_state", state_dbg, ST_IDLE);

        start_run();
        run_bits(0, 14, 30);
        pin_hold(15, 10);
        check("pre_abort_cur", cur_pin, 15);
        check("pre_abort_busy", busy, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cur", cur_pin, 0);
        check("abort_state", state_dbg, ST_IDLE);
        check("abort_pass", pass, 0);
        check("abort_fail", fail, 0);

        gpio_in = '0;
        step(4);
        arm = 1'b1;
        abort = 1'b1;
        step(1);
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_state", state_dbg, ST_IDLE);
        step(2);
        check("arm_abort_busy", busy, 0);

        // Asynchronous reset in the middle of a check.
        start_run();
        run_bits(0, 5, 30);
        pin_hold(6, 10);
        check("pre_rst_cur", cur_pin, 6);
        #1 nrst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_cur", cur_pin, 0);
        check("async_rst_state", state_dbg, ST_IDLE);
        check("async_rst_fail", fail, 0);
        gpio_in = '0;
        step(2);
        nrst = 1'b1;
        step(3);

        pulse_arm();
        run_bits(0, 33, 30);
        hold('0, 5);
        check("post_rst_pass", pass, 1);
        check("post_rst_code", err_code, 0);
        check("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
